// File: rtl/watch_set_ctrl.sv
// rtl/watch_set_ctrl.sv - RUN/SET mode controller with digit select, up/down hold-to-repeat and blink phase
// Optional feature: define WATCH_SET_TIMEOUT_EN to leave SET after TIMEOUT_TICKS idle ticks.
module watch_set_ctrl #(
   parameter int NUM_POS       = 4,
   parameter int HOLD_TICKS    = 500,
   parameter int REPEAT_TICKS  = 100,
   parameter int BLINK_TICKS   = 250,
   parameter int TIMEOUT_TICKS = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic       stop,
   output logic [2:0] digit_pos,
   output logic       time_up,
   output logic       time_down,
   output logic       blink_on
);

   typedef enum logic {ST_RUN = 1'b0, ST_SET = 1'b1} state_t;

   // One width serves every tick counter so all terminal counts fit.
   localparam int T_A  = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
   localparam int T_B  = (BLINK_TICKS > TIMEOUT_TICKS) ? BLINK_TICKS : TIMEOUT_TICKS;
   localparam int T_MX = (T_A > T_B) ? T_A : T_B;
   localparam int CW   = $clog2(T_MX + 1);

   localparam logic [CW-1:0] HOLD_C   = CW'(HOLD_TICKS);
   localparam logic [CW-1:0] REPEAT_C = CW'(REPEAT_TICKS);
   localparam logic [CW-1:0] BLINK_C  = CW'(BLINK_TICKS);
   localparam logic [2:0]    POS_LAST = 3'(NUM_POS - 1);

   // Button vector bit order: {mode, left, right, up, down}
   logic [4:0]    btn_q, btn_d, prev_q, prev_d, press;
   state_t        state_q, state_d;
   logic [2:0]    pos_q, pos_d;
   logic          up_q, up_d, dn_q, dn_d, blink_q, blink_d;
   logic [CW-1:0] blink_cnt_q, blink_cnt_d, rep_cnt_q, rep_cnt_d;
   logic [CW-1:0] rep_inc, blink_inc;
   logic          rep_up_q, rep_up_d, rep_dn_q, rep_dn_d, rep_ph_q, rep_ph_d;
   logic          move, timeout;

`ifdef WATCH_SET_TIMEOUT_EN
   logic [CW-1:0] idle_q, idle_d;
   assign timeout = (idle_q == CW'(TIMEOUT_TICKS));
`else
   assign timeout = 1'b0;
`endif

   assign press     = btn_q & ~prev_q;
   assign rep_inc   = rep_cnt_q + 1'b1;
   assign blink_inc = blink_cnt_q + 1'b1;

   // Next-state: mode FSM, digit select, repeat machinery, blink and idle counters
   always_comb begin
      btn_d       = {btn_mode, btn_left, btn_right, btn_up, btn_down};
      prev_d      = btn_q;
      state_d     = state_q;
      pos_d       = pos_q;
      up_d        = 1'b0;
      dn_d        = 1'b0;
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      rep_up_d    = rep_up_q;
      rep_dn_d    = rep_dn_q;
      rep_ph_d    = rep_ph_q;
      move        = 1'b0;
`ifdef WATCH_SET_TIMEOUT_EN
      idle_d      = idle_q;
`endif
      case (state_q)
         ST_RUN: begin
            rep_up_d  = 1'b0;
            rep_dn_d  = 1'b0;
            rep_ph_d  = 1'b0;
            rep_cnt_d = '0;
            blink_d   = 1'b0;
            if (press[4]) begin
               state_d     = ST_SET;
               pos_d       = 3'd0;
               blink_d     = 1'b1;
               blink_cnt_d = '0;
`ifdef WATCH_SET_TIMEOUT_EN
               idle_d      = '0;
`endif
            end
         end
         default: begin
            if (press[4] || timeout) begin
               // Leaving SET drops blink and cancels any pending repeat.
               state_d   = ST_RUN;
               blink_d   = 1'b0;
               rep_up_d  = 1'b0;
               rep_dn_d  = 1'b0;
               rep_ph_d  = 1'b0;
               rep_cnt_d = '0;
            end else begin
               if (press[3] && !press[2]) begin
                  pos_d = (pos_q == POS_LAST) ? 3'd0 : pos_q + 3'd1;
                  move  = 1'b1;
               end else if (press[2] && !press[3]) begin
                  pos_d = (pos_q == 3'd0) ? POS_LAST : pos_q - 3'd1;
                  move  = 1'b1;
               end
               if (btn_q[1] && btn_q[0]) begin
                  // Both held: disarm so the survivor needs a fresh press.
                  rep_up_d  = 1'b0;
                  rep_dn_d  = 1'b0;
                  rep_ph_d  = 1'b0;
                  rep_cnt_d = '0;
               end else if (press[1] || press[0]) begin
                  up_d      = press[1];
                  dn_d      = press[0];
                  rep_up_d  = press[1];
                  rep_dn_d  = press[0];
                  rep_ph_d  = 1'b0;
                  rep_cnt_d = '0;
               end else if ((rep_up_q && !btn_q[1]) || (rep_dn_q && !btn_q[0])) begin
                  rep_up_d  = 1'b0;
                  rep_dn_d  = 1'b0;
                  rep_ph_d  = 1'b0;
                  rep_cnt_d = '0;
               end else if ((rep_up_q || rep_dn_q) && tick) begin
                  if (rep_inc == (rep_ph_q ? REPEAT_C : HOLD_C)) begin
                     up_d      = rep_up_q;
                     dn_d      = rep_dn_q;
                     rep_ph_d  = 1'b1;
                     rep_cnt_d = '0;
                  end else begin
                     rep_cnt_d = rep_inc;
                  end
               end
               if (move || up_d || dn_d) begin
                  blink_d     = 1'b1;
                  blink_cnt_d = '0;
               end else if (tick) begin
                  if (blink_inc == BLINK_C) begin
                     blink_d     = ~blink_q;
                     blink_cnt_d = '0;
                  end else begin
                     blink_cnt_d = blink_inc;
                  end
               end
`ifdef WATCH_SET_TIMEOUT_EN
               if ((|press[3:0]) || up_d || dn_d) begin
                  idle_d = '0;
               end else if (tick) begin
                  idle_d = idle_q + 1'b1;
               end
`endif
            end
         end
      endcase
   end

   // State registers; buttons reset to "held" so a level present at reset release is not a press
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_q       <= '1;
         prev_q      <= '1;
         state_q     <= ST_RUN;
         pos_q       <= 3'd0;
         up_q        <= 1'b0;
         dn_q        <= 1'b0;
         blink_q     <= 1'b0;
         blink_cnt_q <= '0;
         rep_cnt_q   <= '0;
         rep_up_q    <= 1'b0;
         rep_dn_q    <= 1'b0;
         rep_ph_q    <= 1'b0;
`ifdef WATCH_SET_TIMEOUT_EN
         idle_q      <= '0;
`endif
      end else begin
         btn_q       <= btn_d;
         prev_q      <= prev_d;
         state_q     <= state_d;
         pos_q       <= pos_d;
         up_q        <= up_d;
         dn_q        <= dn_d;
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_up_q    <= rep_up_d;
         rep_dn_q    <= rep_dn_d;
         rep_ph_q    <= rep_ph_d;
`ifdef WATCH_SET_TIMEOUT_EN
         idle_q      <= idle_d;
`endif
      end
   end

   assign stop      = (state_q == ST_SET);
   assign digit_pos = pos_q;
   assign time_up   = up_q;
   assign time_down = dn_q;
   assign blink_on  = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb/tb_watch_set_ctrl.sv - self-checking bench for watch_set_ctrl with a tick-level behavioural model
`timescale 1ns/1ps
module tb_watch_set_ctrl;
   localparam int NP = 4;
   localparam int HT = 5;
   localparam int RT = 2;
   localparam int BT = 3;
   localparam int TT = 20;
   localparam int B_MODE = 4, B_LEFT = 3, B_RIGHT = 2, B_UP = 1, B_DOWN = 0;

   logic       clk = 1'b0;
   logic       rst, tick, btn_mode, btn_left, btn_right, btn_up, btn_down;
   logic       stop, time_up, time_down, blink_on;
   logic [2:0] digit_pos;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   watch_set_ctrl #(
      .NUM_POS(NP), .HOLD_TICKS(HT), .REPEAT_TICKS(RT), .BLINK_TICKS(BT), .TIMEOUT_TICKS(TT)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick),
      .btn_mode(btn_mode), .btn_left(btn_left), .btn_right(btn_right),
      .btn_up(btn_up), .btn_down(btn_down),
      .stop(stop), .digit_pos(digit_pos), .time_up(time_up),
      .time_down(time_down), .blink_on(blink_on)
   );

   // Behavioural model: ticks held since press, ticks since blink restart, idle ticks
   bit       m_set, m_up, m_dn;
   int       m_pos, m_bt, m_held, m_rep, m_idle;
   bit [4:0] m_lvl, m_prv;

   always @(posedge clk) begin : model
      bit [4:0] pr;
      bit       mv, leave;
      if (rst) begin
         m_set = 0; m_pos = 0; m_up = 0; m_dn = 0; m_bt = 0;
         m_held = 0; m_rep = 0; m_idle = 0;
         m_lvl = '1; m_prv = '1;
      end else begin
         pr = m_lvl & ~m_prv;
         m_up = 0; m_dn = 0; mv = 0;
         leave = pr[B_MODE];
`ifdef WATCH_SET_TIMEOUT_EN
         if (m_idle >= TT) leave = 1;
`endif
         if (!m_set) begin
            m_rep = 0;
            if (pr[B_MODE]) begin
               m_set = 1; m_pos = 0; m_bt = 0; m_idle = 0;
            end
         end else if (leave) begin
            m_set = 0; m_rep = 0;
         end else begin
            if (pr[B_LEFT] && !pr[B_RIGHT]) begin m_pos = (m_pos + 1) % NP; mv = 1; end
            else if (pr[B_RIGHT] && !pr[B_LEFT]) begin m_pos = (m_pos + NP - 1) % NP; mv = 1; end
            if (m_lvl[B_UP] && m_lvl[B_DOWN]) m_rep = 0;
            else if (pr[B_UP]) begin m_up = 1; m_rep = 1; m_held = 0; end
            else if (pr[B_DOWN]) begin m_dn = 1; m_rep = 2; m_held = 0; end
            else if ((m_rep == 1 && !m_lvl[B_UP]) || (m_rep == 2 && !m_lvl[B_DOWN])) m_rep = 0;
            else if (m_rep != 0 && tick) begin
               m_held++;
               if (m_held >= HT && (m_held - HT) % RT == 0) begin
                  if (m_rep == 1) m_up = 1; else m_dn = 1;
               end
            end
            if (mv || m_up || m_dn) m_bt = 0;
            else if (tick) m_bt++;
            if (pr[3:0] != 0 || m_up || m_dn) m_idle = 0;
            else if (tick) m_idle++;
         end
         m_prv = m_lvl;
         m_lvl = {btn_mode, btn_left, btn_right, btn_up, btn_down};
      end
   end

   task automatic clk1(input bit t);
      tick = t;
      @(negedge clk);
   endtask

   task automatic set_btn(input int b, input bit v);
      case (b)
         B_MODE:  btn_mode  = v;
         B_LEFT:  btn_left  = v;
         B_RIGHT: btn_right = v;
         B_UP:    btn_up    = v;
         default: btn_down  = v;
      endcase
   endtask

   task automatic press_btn(input int b);
      set_btn(b, 1'b1); clk1(0); clk1(0);
      set_btn(b, 1'b0); clk1(0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn_mode = 0; btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
      clk1(0); clk1(0);
      rst = 1'b0;
      clk1(0);
      checks++; if (stop !== 1'b0) begin errors++; $display("FAIL reset_stop got %b want 0", stop); end
      checks++; if (digit_pos !== 3'd0) begin errors++; $display("FAIL reset_pos got %0d want 0", digit_pos); end
      checks++; if (time_up !== 1'b0) begin errors++; $display("FAIL reset_up got %b want 0", time_up); end
      checks++; if (time_down !== 1'b0) begin errors++; $display("FAIL reset_down got %b want 0", time_down); end
      checks++; if (blink_on !== 1'b0) begin errors++; $display("FAIL reset_blink got %b want 0", blink_on); end
   endtask

   task automatic test_mode();
      set_btn(B_MODE, 1); clk1(0);
      checks++; if (stop !== 1'b0) begin errors++; $display("FAIL mode_latency got %b want 0", stop); end
      clk1(0);
      checks++; if (stop !== 1'b1) begin errors++; $display("FAIL mode_enter_stop got %b want 1", stop); end
      checks++; if (digit_pos !== 3'd0) begin errors++; $display("FAIL mode_enter_pos got %0d want 0", digit_pos); end
      checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL mode_enter_blink got %b want 1", blink_on); end
      set_btn(B_MODE, 0); clk1(0); clk1(0);
      checks++; if (stop !== 1'b1) begin errors++; $display("FAIL mode_release_stop got %b want 1", stop); end
      set_btn(B_MODE, 1); clk1(0); clk1(0);
      checks++; if (stop !== 1'b0) begin errors++; $display("FAIL mode_exit_stop got %b want 0", stop); end
      checks++; if (blink_on !== 1'b0) begin errors++; $display("FAIL mode_exit_blink got %b want 0", blink_on); end
      set_btn(B_MODE, 0); clk1(0); clk1(0);
   endtask

   task automatic test_digit();
      press_btn(B_MODE);
      checks++; if (stop !== 1'b1) begin errors++; $display("FAIL digit_in_set got %b want 1", stop); end
      press_btn(B_RIGHT);
      checks++; if (digit_pos !== 3'd3) begin errors++; $display("FAIL digit_right_wrap got %0d want 3", digit_pos); end
      press_btn(B_LEFT);
      press_btn(B_LEFT);
      checks++; if (digit_pos !== 3'd1) begin errors++; $display("FAIL digit_left2 got %0d want 1", digit_pos); end
      btn_left = 1; btn_right = 1; clk1(0); clk1(0);
      btn_left = 0; btn_right = 0; clk1(0);
      checks++; if (digit_pos !== 3'd1) begin errors++; $display("FAIL digit_both got %0d want 1", digit_pos); end
   endtask

   task automatic test_repeat();
      int  ups = 0, dns = 0, wide = 0;
      bit  prev_up = 0;
      set_btn(B_UP, 1);
      for (int i = 0; i < 16; i++) begin
         if (i == 12) set_btn(B_UP, 0);
         for (int j = 0; j < 3; j++) begin
            clk1(i < 12 && j == 0);
            if (time_up) begin ups++; if (prev_up) wide++; end
            if (time_down) dns++;
            prev_up = time_up;
         end
      end
      checks++; if (ups !== 5) begin errors++; $display("FAIL repeat_count got %0d want 5", ups); end
      checks++; if (wide !== 0) begin errors++; $display("FAIL repeat_width got %0d want 0", wide); end
      checks++; if (dns !== 0) begin errors++; $display("FAIL repeat_down got %0d want 0", dns); end
   endtask

   task automatic test_both();
      int ups = 0, any = 0;
      set_btn(B_UP, 1);
      for (int i = 0; i < 6; i++) for (int j = 0; j < 3; j++) begin
         clk1(j == 0); if (time_up) ups++;
      end
      checks++; if (ups !== 2) begin errors++; $display("FAIL both_prehold got %0d want 2", ups); end
      set_btn(B_DOWN, 1); clk1(0); clk1(0); clk1(0);
      for (int i = 0; i < 6; i++) for (int j = 0; j < 3; j++) begin
         clk1(j == 0); if (time_up || time_down) any++;
      end
      checks++; if (any !== 0) begin errors++; $display("FAIL both_held got %0d want 0", any); end
      set_btn(B_DOWN, 0); any = 0;
      for (int i = 0; i < 6; i++) for (int j = 0; j < 3; j++) begin
         clk1(j == 0); if (time_up || time_down) any++;
      end
      checks++; if (any !== 0) begin errors++; $display("FAIL both_survivor got %0d want 0", any); end
      set_btn(B_UP, 0); clk1(0); clk1(0);
      set_btn(B_UP, 1); ups = 0;
      for (int j = 0; j < 3; j++) begin clk1(0); if (time_up) ups++; end
      checks++; if (ups !== 1) begin errors++; $display("FAIL both_repress got %0d want 1", ups); end
      set_btn(B_UP, 0); clk1(0); clk1(0);
   endtask

   task automatic test_blink();
      press_btn(B_LEFT);
      checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL blink_move got %b want 1", blink_on); end
      clk1(1); clk1(1);
      checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL blink_t2 got %b want 1", blink_on); end
      clk1(1);
      checks++; if (blink_on !== 1'b0) begin errors++; $display("FAIL blink_t3 got %b want 0", blink_on); end
      clk1(1); clk1(1);
      checks++; if (blink_on !== 1'b0) begin errors++; $display("FAIL blink_t5 got %b want 0", blink_on); end
      clk1(1);
      checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL blink_t6 got %b want 1", blink_on); end
      clk1(1); clk1(1); clk1(1); clk1(1);
      checks++; if (blink_on !== 1'b0) begin errors++; $display("FAIL blink_mid got %b want 0", blink_on); end
      press_btn(B_LEFT);
      checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL blink_force got %b want 1", blink_on); end
      clk1(1); clk1(1);
      checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL blink_restart2 got %b want 1", blink_on); end
      clk1(1);
      checks++; if (blink_on !== 1'b0) begin errors++; $display("FAIL blink_restart3 got %b want 0", blink_on); end
   endtask

   task automatic test_timeout();
`ifdef WATCH_SET_TIMEOUT_EN
      int keep;
      press_btn(B_LEFT);
      for (int i = 0; i < 19; i++) clk1(1);
      press_btn(B_LEFT);
      keep = m_pos;
      for (int i = 0; i < 19; i++) clk1(1);
      checks++; if (stop !== 1'b1) begin errors++; $display("FAIL timeout_restart got %b want 1", stop); end
      clk1(1);
      checks++; if (stop !== 1'b1) begin errors++; $display("FAIL timeout_t20 got %b want 1", stop); end
      clk1(0);
      checks++; if (stop !== 1'b0) begin errors++; $display("FAIL timeout_exit got %b want 0", stop); end
      checks++; if (blink_on !== 1'b0) begin errors++; $display("FAIL timeout_blink got %b want 0", blink_on); end
      checks++; if (digit_pos !== 3'(keep)) begin errors++; $display("FAIL timeout_pos got %0d want %0d", digit_pos, keep); end
`else
      for (int i = 0; i < 1000; i++) begin clk1(1); clk1(0); end
      checks++; if (stop !== 1'b1) begin errors++; $display("FAIL no_timeout got %b want 1", stop); end
`endif
   endtask

   task automatic test_reset_mid();
      int ups = 0;
      if (!m_set) press_btn(B_MODE);
      set_btn(B_UP, 1); clk1(0); clk1(0); clk1(1); clk1(1);
      rst = 1'b1; clk1(0);
      checks++; if (stop !== 1'b0) begin errors++; $display("FAIL rstmid_stop got %b want 0", stop); end
      checks++; if (digit_pos !== 3'd0) begin errors++; $display("FAIL rstmid_pos got %0d want 0", digit_pos); end
      checks++; if (blink_on !== 1'b0) begin errors++; $display("FAIL rstmid_blink got %b want 0", blink_on); end
      rst = 1'b0; clk1(0); clk1(0);
      press_btn(B_MODE);
      for (int i = 0; i < 8; i++) for (int j = 0; j < 3; j++) begin
         clk1(j == 0); if (time_up) ups++;
      end
      checks++; if (ups !== 0) begin errors++; $display("FAIL rstmid_nopress got %0d want 0", ups); end
      checks++; if (stop !== 1'b1) begin errors++; $display("FAIL rstmid_set got %b want 1", stop); end
      set_btn(B_UP, 0); clk1(0); clk1(0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 799) == 0);
         if ($urandom_range(0, 59) == 0) btn_mode  = ~btn_mode;
         if ($urandom_range(0, 11) == 0) btn_left  = ~btn_left;
         if ($urandom_range(0, 11) == 0) btn_right = ~btn_right;
         if ($urandom_range(0, 29) == 0) btn_up    = ~btn_up;
         if ($urandom_range(0, 29) == 0) btn_down  = ~btn_down;
         clk1($urandom_range(0, 2) == 0);
         checks++; if (stop !== m_set) begin errors++; $display("FAIL rnd_stop cyc %0d got %b want %b", i, stop, m_set); end
         checks++; if (digit_pos !== 3'(m_pos)) begin errors++; $display("FAIL rnd_pos cyc %0d got %0d want %0d", i, digit_pos, m_pos); end
         checks++; if (time_up !== m_up) begin errors++; $display("FAIL rnd_up cyc %0d got %b want %b", i, time_up, m_up); end
         checks++; if (time_down !== m_dn) begin errors++; $display("FAIL rnd_down cyc %0d got %b want %b", i, time_down, m_dn); end
         checks++;
         if (blink_on !== (m_set && ((m_bt / BT) % 2 == 0))) begin
            errors++; $display("FAIL rnd_blink cyc %0d got %b want %b", i, blink_on, (m_set && ((m_bt / BT) % 2 == 0)));
         end
         checks++; if (time_up && time_down) begin errors++; $display("FAIL rnd_excl cyc %0d got 11 want not both", i); end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      tick = 1'b0;
      test_reset();
      test_mode();
      test_digit();
      test_repeat();
      test_both();
      test_blink();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/watch_set_ctrl.md
# watch_set_ctrl

Set-mode controller for the multi-sensing watch datapath. Decodes debounced button levels into a RUN/SET mode, a digit-position selector, and single-cycle up/down commands with hold-to-repeat. Outputs drive the watch datapath's stop, position and up/down inputs, plus a blink phase for the display. Optionally returns to RUN after an inactivity timeout.

## Interface
- NUM_POS, 4: number of selectable digit positions (2..8).
- HOLD_TICKS, 500: ticks of continuous up/down hold before auto-repeat starts.
- REPEAT_TICKS, 100: ticks between auto-repeat pulses.
- BLINK_TICKS, 250: ticks per blink half-period.
- TIMEOUT_TICKS, 10000: idle ticks in SET before auto-exit (only with macro).
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- tick  in  1  1 ms strobe, one clk wide
- btn_mode  in  1  mode button level, debounced
- btn_left  in  1  left button level
- btn_right  in  1  right button level
- btn_up  in  1  up button level
- btn_down  in  1  down button level
- stop  out  1  1 while in SET; freezes time counting
- digit_pos  out  3  selected digit, 0..NUM_POS-1
- time_up  out  1  one-cycle increment command
- time_down  out  1  one-cycle decrement command
- blink_on  out  1  display phase for the selected digit; 1 = show

## Operation
- Inputs are registered once; press = rising edge of the registered level.
- States: RUN, SET.
- RUN: stop=0, time_up/time_down=0, blink_on=0; digit_pos holds its last value. A btn_mode press -> SET, digit_pos=0, blink_on=1, blink and idle counters cleared.
- SET: stop=1. A btn_mode press -> RUN. A btn_mode press in the same cycle as any other press: the mode press is handled and the others are ignored.
- Left press: digit_pos+1, wrapping NUM_POS-1 -> 0. Right press: digit_pos-1, wrapping 0 -> NUM_POS-1. Left and right pressed in the same cycle: both ignored.
- Up press with btn_down low: one time_up pulse, then the hold counter starts. When hold reaches HOLD_TICKS, another pulse, then one pulse every REPEAT_TICKS while still held. Down is symmetric with time_down.
- btn_up and btn_down both high: no pulses, and the repeat machinery is cleared. Releasing one of them does not count as a new press; the remaining button repeats only after it is released and pressed again.
- Blink: blink_on toggles every BLINK_TICKS ticks in SET. Any digit move or up/down pulse forces blink_on=1 and clears the blink counter.
- time_up and time_down are never both 1 and are never asserted in RUN.

## Timing
- Reset values: state=RUN, stop=0, digit_pos=0, time_up=0, time_down=0, blink_on=0; all counters 0.
- All outputs are registered. A button level change at clk edge N appears in the input register at N+1, and the response is visible after edge N+2 (2-cycle latency).
- Counters advance only on cycles with tick=1. Repeat pulses are emitted in the cycle after the counter hits its terminal count.
- Leaving SET, whether by btn_mode or timeout: stop=0 and blink_on=0 in the same cycle, and any pending repeat is cancelled.
- Reset asserted mid-hold or mid-SET: the reset values apply on the next edge. A button still held when reset is released does not generate a press.

## Configuration
- WATCH_SET_TIMEOUT_EN defined:
  - An idle counter runs in SET on ticks and is cleared by every press and every repeat pulse.
  - Reaching TIMEOUT_TICKS forces SET -> RUN next cycle.
  - digit_pos is kept.
- Not defined:
  - No idle counter exists.
  - SET is left only via btn_mode or rst.

## Test plan
- Reset, then pulse btn_mode: stop=1, digit_pos=0, blink_on=1 at 2 cycles after the press. Pulse btn_mode again: stop=0, blink_on=0.
- In SET with NUM_POS=4: right press -> digit_pos=3; left x2 -> 1; left and right pressed together -> digit_pos stays 1.
- In SET with HOLD_TICKS=5, REPEAT_TICKS=2: hold btn_up for 12 ticks -> exactly 5 time_up pulses, each 1 cycle wide; time_down stays 0.
- Hold btn_up, then assert btn_down: pulses stop immediately. Drop btn_down while btn_up is held: no pulses until btn_up is re-pressed.
- In SET with BLINK_TICKS=3: blink_on toggles every 3 ticks. A left press mid-period forces blink_on=1 and restarts the period.
- With WATCH_SET_TIMEOUT_EN and TIMEOUT_TICKS=20: 20 idle ticks in SET -> stop falls. A press at tick 19 restarts the count. Without the macro, stop stays 1 after 1000 ticks.
